// File: rtl/word_ser_pkg.sv
// Shared definitions for the word serializer: state encoding, line level, defaults.
package word_ser_pkg;

    localparam int unsigned DEF_WIDTH        = 16;
    localparam int unsigned DEF_CLKS_PER_BIT = 4;
    localparam int unsigned STATE_W          = 3;

    // Serial line level when no frame is on the wire
    localparam logic LINE_IDLE = 1'b1;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_START  = 3'd1;
    localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] ST_STOP   = 3'd3;
    localparam logic [STATE_W-1:0] ST_PARITY = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        STOP   = ST_STOP,
        PARITY = ST_PARITY
    } ser_state_t;

endpackage

// File: rtl/word_serializer_bit_timer.sv
// bit_timer: period counter for one serial bit; runs 0..CLKS_PER_BIT-1 while enabled.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic bit_end_c
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    assign bit_end_c = en && (cnt_q == LAST);

    // Count while enabled, wrap at the last clock of the bit, park at zero otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (!en || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/word_serializer.sv
// word_serializer: accepts a parallel word on valid/ready and sends start, data MSB-first,
// optional even parity, and stop bits on tx. Optional parity build: WORD_SERIALIZER_PARITY_EN.
module word_serializer
    import word_ser_pkg::*;
#(
    parameter int unsigned WIDTH        = DEF_WIDTH,
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    ser_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_dec;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             tx_d, busy_d, done_d, ready_d;
    logic             bit_end_c;

    assign idx_dec = idx_q - IDX_W'(1);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (state_q != IDLE),
        .bit_end_c(bit_end_c)
    );

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            hold_q     <= '0;
            tx         <= LINE_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            data_ready <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            tx         <= tx_d;
            busy       <= busy_d;
            done       <= done_d;
            data_ready <= ready_d;
        end
    end

    // Next state and next output values; tx_d is the line level of the state being entered
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        tx_d    = LINE_IDLE;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                if (data_valid && data_ready) begin
                    state_d = START;
                    hold_d  = data_in;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end_c) begin
                    state_d = DATA;
                    idx_d   = IDX_W'(WIDTH - 1);
                    tx_d    = hold_q[WIDTH-1];
                end
            end
            DATA: begin
                tx_d = hold_q[idx_q];
                if (bit_end_c) begin
                    if (idx_q == '0) begin
`ifdef WORD_SERIALIZER_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^hold_q;
`else
                        state_d = STOP;
                        tx_d    = LINE_IDLE;
`endif
                    end else begin
                        idx_d = idx_dec;
                        tx_d  = hold_q[idx_dec];
                    end
                end
            end
`ifdef WORD_SERIALIZER_PARITY_EN
            PARITY: begin
                tx_d = ^hold_q;
                if (bit_end_c) begin
                    state_d = STOP;
                    tx_d    = LINE_IDLE;
                end
            end
`endif
            STOP: begin
                tx_d = LINE_IDLE;
                if (bit_end_c) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = LINE_IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer; frame tables follow WORD_SERIALIZER_PARITY_EN.
module tb_word_serializer;

    localparam int unsigned W   = 16;
    localparam int unsigned CPB = 4;
`ifdef WORD_SERIALIZER_PARITY_EN
    localparam int unsigned FB  = W + 3;
`else
    localparam int unsigned FB  = W + 2;
`endif
    localparam int unsigned N   = FB * CPB;
    localparam int unsigned NV  = 4;

    typedef struct {
        string         name;
        logic [W-1:0]  data;
        logic [FB-1:0] frame;   // serial bits, first bit on the wire in the MSB
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] data_in;
    logic         data_valid;
    logic         data_ready;
    logic         tx;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vecs[NV];
    vec_t v_ffff, v_0000;

    word_serializer #(
        .WIDTH       (W),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string name, input logic e_tx, input logic e_busy,
                               input logic e_ready, input logic e_done);
        chk({name, " tx"},    tx,         e_tx);
        chk({name, " busy"},  busy,       e_busy);
        chk({name, " ready"}, data_ready, e_ready);
        chk({name, " done"},  done,       e_done);
    endtask

    // Caller has just driven data_valid=1 at a falling edge; checks every clock of the frame
    // and the done cycle, returning at the falling edge of the done cycle.
    // mode 0: drop valid after accept; 1: keep valid high; 2: also disturb inputs mid-frame.
    task automatic check_frame(input vec_t v, input int mode);
        int   bi;
        logic e;
        for (int c = 1; c <= int'(N); c++) begin
            @(negedge clk);
            bi = int'(FB) - 1 - (c - 1) / int'(CPB);
            e  = v.frame[bi];
            chk_outputs($sformatf("%s c%0d", v.name, c), e, 1'b1, 1'b0, 1'b0);
            if (c == 1 && mode != 1) data_valid = 1'b0;
            if (mode == 2) begin
                if (c == 2)  data_in = 16'h0F0F;
                if (c == 20) begin data_in = 16'h1234; data_valid = 1'b1; end
                if (c == 21) data_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk_outputs({v.name, " done cycle"}, 1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
`ifdef WORD_SERIALIZER_PARITY_EN
        vecs[0] = '{"A5C3", 16'hA5C3, 19'b0_1010_0101_1100_0011_0_1};
        vecs[1] = '{"0007", 16'h0007, 19'b0_0000_0000_0000_0111_1_1};
        vecs[2] = '{"0003", 16'h0003, 19'b0_0000_0000_0000_0011_0_1};
        vecs[3] = '{"0001", 16'h0001, 19'b0_0000_0000_0000_0001_1_1};
        v_ffff  = '{"FFFF", 16'hFFFF, 19'b0_1111_1111_1111_1111_0_1};
        v_0000  = '{"0000", 16'h0000, 19'b0_0000_0000_0000_0000_0_1};
`else
        vecs[0] = '{"A5C3", 16'hA5C3, 18'b0_1010_0101_1100_0011_1};
        vecs[1] = '{"0007", 16'h0007, 18'b0_0000_0000_0000_0111_1};
        vecs[2] = '{"0003", 16'h0003, 18'b0_0000_0000_0000_0011_1};
        vecs[3] = '{"0001", 16'h0001, 18'b0_0000_0000_0000_0001_1};
        v_ffff  = '{"FFFF", 16'hFFFF, 18'b0_1111_1111_1111_1111_1};
        v_0000  = '{"0000", 16'h0000, 18'b0_0000_0000_0000_0000_1};
`endif

        // Reset and idle
        reset_n    = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        repeat (3) @(negedge clk);
        chk_outputs("in reset", 1'b1, 1'b0, 1'b1, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        chk_outputs("idle", 1'b1, 1'b0, 1'b1, 1'b0);

        // Table-driven single frames
        for (int i = 0; i < int'(NV); i++) begin
            data_in    = vecs[i].data;
            data_valid = 1'b1;
            check_frame(vecs[i], 0);
            @(negedge clk);
            chk_outputs({vecs[i].name, " after done"}, 1'b1, 1'b0, 1'b1, 1'b0);
        end

        // Back-to-back: valid held, second word presented on the done cycle
        data_in    = v_ffff.data;
        data_valid = 1'b1;
        check_frame(v_ffff, 1);
        data_in = v_0000.data;
        check_frame(v_0000, 0);
        @(negedge clk);
        chk_outputs("b2b after done", 1'b1, 1'b0, 1'b1, 1'b0);

        // Input changes and stray valid pulses during a frame are ignored
        data_in    = vecs[0].data;
        data_valid = 1'b1;
        check_frame(vecs[0], 2);
        @(negedge clk);
        chk_outputs("ignored after done", 1'b1, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset during data bit 7 of 8001 (cycles 37..40 after accept)
        data_in    = 16'h8001;
        data_valid = 1'b1;
        for (int c = 1; c <= 38; c++) begin
            @(negedge clk);
            if (c == 1) data_valid = 1'b0;
        end
        chk("8001 bit7 before reset", tx, 1'b0);
        chk("8001 busy before reset", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk_outputs("async reset", 1'b1, 1'b0, 1'b1, 1'b0);
        data_in    = 16'h1234;
        data_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk_outputs("valid during reset", 1'b1, 1'b0, 1'b1, 1'b0);
        end
        data_valid = 1'b0;
        reset_n    = 1'b1;
        @(negedge clk);
        chk_outputs("after reset release", 1'b1, 1'b0, 1'b1, 1'b0);
        data_in    = vecs[3].data;
        data_valid = 1'b1;
        check_frame(vecs[3], 0);
        @(negedge clk);
        chk_outputs("post-reset frame after done", 1'b1, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
Downstream stage of the 16-bit shift register. Accepts one parallel word over a valid/ready handshake and transmits it as a framed serial bit stream on a single line:
- start bit, then data MSB-first, then stop bit.
- Each bit is held for CLKS_PER_BIT clocks.
- Feeds the board's serial output pin or the lab's loopback receiver.

Parameters:
WIDTH, 16, data word width in bits (matches the shift register's output width).
CLKS_PER_BIT, 4, clocks per serial bit; legal range is 2 or more.

Ports:
clk  input  1  system clock; rising edge.
reset_n  input  1  asynchronous active-low reset.
data_in  input  WIDTH  parallel word to transmit.
data_valid  input  1  data_in is valid this cycle.
data_ready  output  1  block can accept a word this cycle.
tx  output  1  serial line; idles high.
busy  output  1  a frame is in progress.
done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset is applied immediately when reset_n falls, independent of clk:
  - state=IDLE, tx=1, busy=0, done=0, data_ready=1.
  - Bit counter, period counter and holding register are cleared.
- Handshake:
  - Accept occurs on a rising edge where data_valid=1 and data_ready=1.
  - data_ready=1 only in IDLE; data_ready is registered.
  - data_in is captured into the holding register on accept; later changes to data_in are ignored.
  - data_valid while not ready is ignored; the word is not queued.
- Period counter:
  - Counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - bit_end is asserted when count = CLKS_PER_BIT-1.
  - The counter wraps to 0 on bit_end.
  - The counter width is clog2(CLKS_PER_BIT).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. On accept, go to START; busy=1 and data_ready=0 from the next cycle.
  - START: tx=0 for CLKS_PER_BIT clocks. On bit_end go to DATA with bit index = WIDTH-1.
  - DATA: tx = hold[bit index]. On bit_end, decrement the index. When the index is 0 and bit_end occurs, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT clocks. On bit_end go to IDLE, and done=1 for exactly that next cycle.
- Latency:
  - tx falls on the first clock after accept.
  - Frame length is (WIDTH+2)*CLKS_PER_BIT clocks; 72 with the defaults.
  - data_ready returns to 1 together with done.
- Back-to-back frames:
  - The earliest next accept is on the cycle done=1.
  - The next start bit follows immediately.
  - No extra idle bit is inserted.
- Outputs tx, busy and done are registered, so the line is glitch-free.
- Reset mid-frame: tx returns high immediately and the frame is abandoned. No done pulse is produced.
- Simultaneous data_valid and reset_n low: reset wins and nothing is accepted.
- Unreachable state encodings recover to IDLE with tx=1.

Optional Feature:
Macro WORD_SERIALIZER_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = XOR of all bits of the holding register (even parity) for CLKS_PER_BIT clocks.
  - Frame length is (WIDTH+3)*CLKS_PER_BIT clocks.
- Undefined:
  - The PARITY state and the parity logic are absent.
  - Frame length is (WIDTH+2)*CLKS_PER_BIT clocks.
- Ports are identical in both builds.

Decomposition:
- Shared package word_ser_pkg holds:
  - the state encoding localparams: IDLE=0, START=1, DATA=2, STOP=3, PARITY=4 (3-bit);
  - the idle line level constant (1);
  - the default WIDTH and CLKS_PER_BIT.
- One natural sub-module: bit_timer, the period counter with enable and bit_end output, parameterised by CLKS_PER_BIT.

Test Plan:
1. Reset and idle: hold reset_n=0 for 3 clocks, then release.
   - Required: tx=1, busy=0, data_ready=1, done=0. Assert reset_n=0 mid-clock; outputs must change without waiting for an edge.
2. Single frame with defaults: data_in=16'hA5C3, data_valid for 1 cycle.
   - Required: tx low for cycles 1-4 after accept, then bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1, each 4 clocks, then high for 4 clocks.
   - Required: done pulses at cycle 73 after accept and busy covers exactly 72 cycles.
3. Back-to-back: hold data_valid=1 with 16'hFFFF, then 16'h0000 presented on the done cycle.
   - Required: the second start bit begins the cycle after done, with no gap.
   - Required: the first word's data bits are all 1 and the second word's are all 0.
4. Ignored input:
   - Required: pulsing data_valid with 16'h1234 mid-frame has no effect on the frame.
   - Required: changing data_in after accept does not alter the transmitted bits.
5. Reset mid-frame: assert reset_n=0 during data bit 7 of 16'h8001.
   - Required: tx=1 immediately and no done pulse.
   - Required: a new frame of 16'h0001 after release transmits correctly.
6. With WORD_SERIALIZER_PARITY_EN defined, send 16'h0007.
   - Required: parity bit = 1 for 4 clocks before the stop bit; frame length 76 clocks.
   - Required: 16'h0003 gives parity bit = 0.
